// File: rtl/fft_frame_feeder_if.sv
// fft_frame_feeder_if: AXI-Stream link from the frame feeder to the FFT core.
interface fft_frame_feeder_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: ping-pong frame buffer turning a strobed sample stream into AXI-Stream FFT frames.
module fft_frame_feeder #(
    parameter int FRAME_LEN = 8192,
    parameter int SAMPLE_W  = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    fft_frame_feeder_if.master  m_axis,
    output logic                overrun
);
    localparam int AW = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST_IDX = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_t;
    typedef enum logic [1:0] {IDLE, PRIME, STREAM} rd_state_t;

    logic [SAMPLE_W-1:0] r_mem [0:2*FRAME_LEN-1];
    logic [SAMPLE_W-1:0] r_rdata;
    bank_t               r_bank [2];
    bank_t               w_bank_n [2];
    rd_state_t           r_state, w_state_n;
    logic [AW-1:0]       r_wi, r_ri, w_ridx;
    logic                r_rb, w_rbk, r_rd_done, r_rd_v, r_rd_last;
    logic                r_tvalid, r_tlast, r_overrun;
    logic [SAMPLE_W-1:0] r_tdata;
    logic [SAMPLE_W:0]   r_sk [2];
    logic [1:0]          r_sk_cnt, w_cnt, w_widx;
    logic                w_fill_ok, w_wr_b, w_wr, w_wr_end;
    logic                w_hs, w_rel, w_other_full, w_start, w_ren;
    logic                w_free, w_pop, w_push;
    logic [SAMPLE_W:0]   w_arr;

    assign w_fill_ok    = r_bank[0] == FILLING || r_bank[1] == FILLING;
    assign w_wr_b       = r_bank[1] == FILLING;
    assign w_wr         = sample_valid && w_fill_ok && !reset;
    assign w_wr_end     = w_wr && r_wi == LAST_IDX;
    assign w_hs         = r_tvalid && m_axis.tready;
    assign w_rel        = r_state == STREAM && w_hs && r_tlast;
    assign w_other_full = r_bank[!r_rb] == FULL;

    // PRIME means word 0 is already in flight: it is requested on the entering transition
    always_comb begin
        w_state_n = r_state;
        w_bank_n  = r_bank;
        w_start   = 1'b0;
        w_rbk     = r_rb;
        if (w_wr_end) w_bank_n[w_wr_b] = FULL;
        if (r_state == IDLE && r_bank[r_rb] == FULL) begin
            w_state_n      = PRIME;
            w_start        = 1'b1;
            w_bank_n[r_rb] = READING;
        end else if (r_state == PRIME) begin
            w_state_n = STREAM;
        end else if (w_rel) begin
            w_state_n      = w_other_full ? PRIME : IDLE;
            w_start        = w_other_full;
            w_rbk          = !r_rb;
            w_bank_n[r_rb] = EMPTY;
            if (w_other_full) w_bank_n[!r_rb] = READING;
        end
        if (w_bank_n[0] != FILLING && w_bank_n[1] != FILLING) begin
            if (w_bank_n[0] == EMPTY) w_bank_n[0] = FILLING;
            else if (w_bank_n[1] == EMPTY) w_bank_n[1] = FILLING;
        end
    end

    // Reads are throttled so output register + skid + in-flight word never exceed three
    assign w_ridx = w_start ? '0 : r_ri;
    assign w_cnt  = 2'(r_tvalid) + r_sk_cnt + 2'(r_rd_v);
    assign w_ren  = w_start || (!r_rd_done && w_cnt != 2'd3);
    assign w_free = !r_tvalid || w_hs;
    assign w_pop  = w_free && r_sk_cnt != 2'd0;
    assign w_push = r_rd_v && !(w_free && r_sk_cnt == 2'd0);
    assign w_widx = r_sk_cnt - 2'(w_pop);
    assign w_arr  = {r_rd_last, r_rdata};

    always_ff @(posedge clock) begin
        if (w_wr) r_mem[{w_wr_b, r_wi}] <= sample_in;
        if (w_ren) r_rdata <= r_mem[{w_rbk, w_ridx}];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bank[0] <= FILLING;
            r_bank[1] <= EMPTY;
            r_state   <= IDLE;
            r_wi      <= '0;
            r_ri      <= '0;
            r_rb      <= 1'b0;
            r_rd_done <= 1'b1;
            r_rd_v    <= 1'b0;
            r_rd_last <= 1'b0;
            r_sk_cnt  <= 2'd0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_tdata   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_bank    <= w_bank_n;
            r_state   <= w_state_n;
            r_overrun <= sample_valid && !w_fill_ok;
            if (w_wr) r_wi <= r_wi + 1'b1;
            if (w_rel) r_rb <= !r_rb;
            if (w_ren) begin
                r_ri      <= w_ridx + 1'b1;
                r_rd_done <= w_ridx == LAST_IDX;
            end
            r_rd_v    <= w_ren;
            r_rd_last <= w_ren && w_ridx == LAST_IDX;
            if (w_free) r_tvalid <= w_pop || r_rd_v;
            if (w_pop) {r_tlast, r_tdata} <= r_sk[0];
            else if (w_free && r_rd_v) {r_tlast, r_tdata} <= w_arr;
            r_sk_cnt <= w_widx + 2'(w_push);
        end
    end

    always_ff @(posedge clock) begin
        if (w_pop) r_sk[0] <= r_sk[1];
        if (w_push) r_sk[w_widx[0]] <= w_arr;
    end

    assign m_axis.tdata  = 32'(r_tdata);
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign overrun       = r_overrun;
endmodule
